// File: rtl/cpu_pkg.sv
// Shared CPU types for the ALU issue path: op encodings, entry payload, issue FSM states.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SUBI = 4'd2,
    SLL  = 4'd3,
    SLT  = 4'd4,
    SLTU = 4'd5,
    XOR  = 4'd6,
    SRL  = 4'd7,
    SRA  = 4'd8,
    OR   = 4'd9,
    AND  = 4'd10
  } alu_op_e;

  typedef struct packed {
    alu_op_e              op;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [RADDR_W-1:0]   rs1_addr;
    logic [RADDR_W-1:0]   rs2_addr;
    logic                 use_imm;
    logic [RADDR_W-1:0]   rd_addr;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_BUSY,
    ST_FULL
  } issue_state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

endpackage

// File: rtl/alu_operand_bypass.sv
// Operand forwarding from the writeback bus plus shift-amount masking.
// Used both on the incoming beat and to refresh operands already held in the stage.
module alu_operand_bypass
  import cpu_pkg::*;
(
  input  alu_op_e              op,
  input  logic [RADDR_W-1:0]   rs1_addr,
  input  logic [RADDR_W-1:0]   rs2_addr,
  input  logic                 use_imm,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      imm,
  input  logic                 wb_en,
  input  logic [RADDR_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic [XLEN-1:0]      op1,
  output logic [XLEN-1:0]      op2
);

  logic [XLEN-1:0] op2_raw;

  // x0 always reads zero, even if something writes back to it.
  function automatic logic [XLEN-1:0] fwd(input logic [RADDR_W-1:0] a,
                                          input logic [XLEN-1:0]    d);
    if (a == '0)                   return '0;
    else if (wb_en && wb_addr == a) return wb_data;
    else                           return d;
  endfunction

  always_comb begin
    op1     = fwd(rs1_addr, rs1_data);
    op2_raw = use_imm ? imm : fwd(rs2_addr, rs2_data);
    op2     = is_shift(op) ? {{(XLEN-SHAMT_W){1'b0}}, op2_raw[SHAMT_W-1:0]} : op2_raw;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute register stage feeding the ALU, with writeback bypass into held operands.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module alu_issue_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [RADDR_W-1:0]   in_rs1_addr,
  input  logic [RADDR_W-1:0]   in_rs2_addr,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [XLEN-1:0]      in_imm,
  input  logic                 in_use_imm,
  input  logic [RADDR_W-1:0]   in_rd_addr,
  input  logic                 wb_en,
  input  logic [RADDR_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_op,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [RADDR_W-1:0]   out_rd_addr
);

  issue_state_e state_q, state_d;
  issue_entry_t main_q, main_d, main_ref, cap;
  logic         accept, xfer, load_main;

  // Incoming beat: unknown op encodings are carried through untouched.
  always_comb begin
    cap          = '0;
    cap.op       = alu_op_e'(in_op);
    cap.rs1_addr = in_rs1_addr;
    cap.rs2_addr = in_rs2_addr;
    cap.use_imm  = in_use_imm;
    cap.rd_addr  = in_rd_addr;
  end

  alu_operand_bypass u_cap_bypass (
    .op(cap.op), .rs1_addr(in_rs1_addr), .rs2_addr(in_rs2_addr), .use_imm(in_use_imm),
    .rs1_data(in_rs1_data), .rs2_data(in_rs2_data), .imm(in_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .op1(), .op2()
  );

  logic [XLEN-1:0] cap_op1, cap_op2, main_op1, main_op2;
  assign cap_op1 = u_cap_bypass.op1;
  assign cap_op2 = u_cap_bypass.op2;

  // Held entries re-run the bypass on their own operands so late writebacks land.
  alu_operand_bypass u_main_bypass (
    .op(main_q.op), .rs1_addr(main_q.rs1_addr), .rs2_addr(main_q.rs2_addr),
    .use_imm(main_q.use_imm), .rs1_data(main_q.op1), .rs2_data(main_q.op2), .imm(main_q.op2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .op1(main_op1), .op2(main_op2)
  );

  always_comb begin
    main_ref     = main_q;
    main_ref.op1 = main_op1;
    main_ref.op2 = main_op2;
  end

  assign out_valid   = (state_q != ST_EMPTY);
  assign out_op      = main_q.op;
  assign out_op1     = main_q.op1;
  assign out_op2     = main_q.op2;
  assign out_rd_addr = main_q.rd_addr;
  assign accept      = in_valid && in_ready;
  assign xfer        = out_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_entry_t    skid_q, skid_d, skid_ref;
  logic [XLEN-1:0] skid_op1, skid_op2;
  logic            load_skid, move_skid;

  alu_operand_bypass u_skid_bypass (
    .op(skid_q.op), .rs1_addr(skid_q.rs1_addr), .rs2_addr(skid_q.rs2_addr),
    .use_imm(skid_q.use_imm), .rs1_data(skid_q.op1), .rs2_data(skid_q.op2), .imm(skid_q.op2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .op1(skid_op1), .op2(skid_op2)
  );

  always_comb begin
    skid_ref     = skid_q;
    skid_ref.op1 = skid_op1;
    skid_ref.op2 = skid_op2;
  end

  // Depends only on state, so out_ready never reaches in_ready combinationally.
  assign in_ready = !rst && (state_q != ST_FULL);
`else
  assign in_ready = !rst && ((state_q == ST_EMPTY) || out_ready);
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    load_main = 1'b0;
`ifdef ALU_ISSUE_SKID_EN
    load_skid = 1'b0;
    move_skid = 1'b0;
`endif
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d   = ST_BUSY;
        load_main = 1'b1;
      end
      ST_BUSY: begin
`ifdef ALU_ISSUE_SKID_EN
        if (accept && !out_ready) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else
`endif
        if (accept) begin
          load_main = 1'b1;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
`ifdef ALU_ISSUE_SKID_EN
      ST_FULL: if (out_ready) begin
        state_d   = ST_BUSY;
        move_skid = 1'b1;
      end
`endif
      default: state_d = ST_EMPTY;
    endcase

    // A redirect discards everything, including a beat arriving this cycle.
    if (flush) begin
      state_d   = ST_EMPTY;
      load_main = 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      load_skid = 1'b0;
      move_skid = 1'b0;
`endif
    end

    main_d     = main_ref;
    if (load_main) begin
      main_d     = cap;
      main_d.op1 = cap_op1;
      main_d.op2 = cap_op2;
    end
`ifdef ALU_ISSUE_SKID_EN
    else if (move_skid) begin
      main_d = skid_ref;
    end
    skid_d = skid_ref;
    if (load_skid) begin
      skid_d     = cap;
      skid_d.op1 = cap_op1;
      skid_d.op2 = cap_op2;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: payload registers are reset too, so the outputs show defined values in reset.
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
`ifdef ALU_ISSUE_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      main_q  <= main_d;
`ifdef ALU_ISSUE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (default build; skid path under ALU_ISSUE_SKID_EN).
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd_addr;

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd_addr(out_rd_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] d1,
                      input logic [4:0] rs2, input logic [31:0] d2, input logic use_imm,
                      input logic [31:0] imm, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_op       = op;
    in_rs1_addr = rs1;
    in_rs1_data = d1;
    in_rs2_addr = rs2;
    in_rs2_data = d2;
    in_use_imm  = use_imm;
    in_imm      = imm;
    in_rd_addr  = rd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_op"},    32'(out_op), 32'd0);
    check({tag, "_op1"},   out_op1, 32'd0);
    check({tag, "_op2"},   out_op2, 32'd0);
    check({tag, "_rd"},    32'(out_rd_addr), 32'd0);
    check({tag, "_rdy"},   32'(in_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_op = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_use_imm = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 0;
    tick(); tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    check("rst_release_rdy", 32'(in_ready), 32'd1);

    // 1: plain ADD, one-cycle latency, valid for exactly one cycle
    out_ready = 1'b1;
    beat(4'd0, 5'd5, 32'd10, 5'd6, 32'd3, 1'b0, 32'd0, 5'd7);
    tick(); in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_op1", out_op1, 32'd10);
    check("t1_op2", out_op2, 32'd3);
    check("t1_rd", 32'(out_rd_addr), 32'd7);
    tick();
    check("t1_drained", 32'(out_valid), 32'd0);

    // 2: writeback bypass into the incoming beat, and x0 ignores writebacks
    beat(4'd0, 5'd5, 32'd10, 5'd6, 32'd3, 1'b0, 32'd0, 5'd7);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd99;
    tick(); in_valid = 1'b0; wb_en = 1'b0;
    check("t2_fwd_op1", out_op1, 32'd99);
    check("t2_fwd_op2", out_op2, 32'd3);
    beat(4'd0, 5'd0, 32'd123, 5'd6, 32'd3, 1'b0, 32'd0, 5'd7);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd7;
    tick(); in_valid = 1'b0; wb_en = 1'b0;
    check("t2_x0_op1", out_op1, 32'd0);

    // 3: shift amount masking for imm and register op2; unknown op unmasked
    beat(4'd3, 5'd5, 32'd10, 5'd6, 32'd3, 1'b1, 32'h25, 5'd8);
    tick();
    check("t3_sll_op", 32'(out_op), 32'd3);
    check("t3_sll_op2", out_op2, 32'd5);
    beat(4'd8, 5'd5, 32'd10, 5'd6, 32'hFFFF_FF21, 1'b0, 32'd0, 5'd8);
    tick();
    check("t3_sra_op2", out_op2, 32'd1);
    beat(4'hF, 5'd5, 32'd10, 5'd6, 32'h25, 1'b0, 32'd0, 5'd8);
    tick(); in_valid = 1'b0;
    check("t3_unk_op", 32'(out_op), 32'hF);
    check("t3_unk_op2", out_op2, 32'h25);
    tick();

    // 4: stall, late writeback refreshes the held op1
    out_ready = 1'b0;
    beat(4'd0, 5'd5, 32'd10, 5'd6, 32'd3, 1'b0, 32'd0, 5'd9);
    tick(); in_valid = 1'b0;
    check("t4_held_valid", 32'(out_valid), 32'd1);
`ifdef ALU_ISSUE_SKID_EN
    beat(4'd1, 5'd2, 32'd20, 5'd3, 32'd4, 1'b0, 32'd0, 5'd10);
    check("t4_skid_rdy", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    check("t4_full_rdy", 32'(in_ready), 32'd0);
`else
    check("t4_stall_rdy", 32'(in_ready), 32'd0);
    tick();
`endif
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd42;
    tick(); wb_en = 1'b0;
    check("t4_ref_op1", out_op1, 32'd42);
    check("t4_ref_op2", out_op2, 32'd3);
    check("t4_ref_rd", 32'(out_rd_addr), 32'd9);
    tick();
    check("t4_hold_op1", out_op1, 32'd42);
    check("t4_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
`ifdef ALU_ISSUE_SKID_EN
    check("t4_b_valid", 32'(out_valid), 32'd1);
    check("t4_b_op", 32'(out_op), 32'd1);
    check("t4_b_op1", out_op1, 32'd20);
    check("t4_b_op2", out_op2, 32'd4);
    check("t4_b_rd", 32'(out_rd_addr), 32'd10);
    tick();
`endif
    check("t4_drained", 32'(out_valid), 32'd0);

    // 5: flush with an entry held and a beat accepted the same cycle
    out_ready = 1'b0;
    beat(4'd0, 5'd5, 32'd10, 5'd6, 32'd3, 1'b0, 32'd0, 5'd9);
    tick();
    check("t5_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    beat(4'd6, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, 5'd11);
    flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    check("t5_flushed", 32'(out_valid), 32'd0);
    check("t5_rdy", 32'(in_ready), 32'd1);
    tick();
    check("t5_no_emit", 32'(out_valid), 32'd0);

    // 6: asynchronous reset while stalled
    out_ready = 1'b0;
    beat(4'd1, 5'd5, 32'd10, 5'd6, 32'd3, 1'b0, 32'd0, 5'd12);
    tick(); in_valid = 1'b0;
    check("t6_held", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    tick(); rst = 1'b0;
    tick();
    check("t6_after", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
